convertidor_bin_a_bcd: RTL and testbench
========================================

// Module: convertidor_bin_a_bcd
// PURPOSE
//  Sequential binary-to-BCD converter (shift-and-add-3) that feeds the 4-digit 7-segment display controller.
//  Accepts an unsigned binary value on a start pulse and produces four BCD digits (units..thousands).
//  Output digits are registered and held until the next conversion completes, so the display never flickers.
//  Values above 9999 saturate to 9999 and raise an overflow flag.
// PARAMETERS
//  ANCHO_BIN   14   width of i_Binario; legal range 4..14; sets iteration count = ANCHO_BIN
// PORTS
//  i_Reloj      in   1          system clock, all state on rising edge
//  i_Reset      in   1          asynchronous, active-high reset
//  i_Binario    in   ANCHO_BIN  unsigned value to convert; sampled only when a start is accepted
//  i_Inicio     in   1          start request; accepted only in REPOSO
//  o_Datos_0    out  4          BCD units      (to display digit 0)
//  o_Datos_1    out  4          BCD tens       (to display digit 1)
//  o_Datos_2    out  4          BCD hundreds   (to display digit 2)
//  o_Datos_3    out  4          BCD thousands  (to display digit 3)
//  o_Ocupado    out  1          high while a conversion is in progress (DESPLAZA, FIN)
//  o_Listo      out  1          one-cycle pulse: new digits valid
//  o_Desborde   out  1          last result saturated (input > 9999); held with digits
// BEHAVIOUR
//  Reset (async, any time): state=REPOSO; o_Datos_0..3=0; o_Ocupado=0; o_Listo=0; o_Desborde=0;
//   internal shift/BCD registers and iteration counter cleared. Reset mid-conversion aborts it; no o_Listo.
//  FSM states: REPOSO, DESPLAZA, FIN.
//  REPOSO: on edge E with i_Inicio=1 -> capture i_Binario into shift reg, clear BCD accumulator (16 b),
//   load counter=ANCHO_BIN, latch ovf=(i_Binario>9999), go DESPLAZA. i_Inicio=0 -> stay.
//  DESPLAZA: each edge does one iteration: every BCD nibble >=5 gets +3, then {bcd,bin} shifts left by 1;
//   counter decrements; the edge performing the last iteration moves to FIN. Exactly ANCHO_BIN edges here.
//  FIN: next edge loads o_Datos_0..3 from accumulator (or 9,9,9,9 if ovf), o_Desborde<=ovf,
//   o_Listo<=1 for one cycle, o_Ocupado<=0, state->REPOSO.
//  Latency: start accepted at edge E; o_Listo high and new digits visible after edge E+ANCHO_BIN+1
//   (15 cycles at default). o_Ocupado high from after edge E until that same edge.
//  i_Inicio while o_Ocupado=1 (DESPLAZA or FIN) is ignored, not queued; input changes during conversion have no effect.
//  Back-to-back: earliest next accept is the edge after o_Listo is asserted (state REPOSO); max throughput
//   one result per ANCHO_BIN+2 cycles.
//  o_Datos_* and o_Desborde change only at the FIN edge or reset; otherwise hold last result.
//  Each nibble of o_Datos_* is always 0..9. With ANCHO_BIN<14 ovf is structurally 0.
//  Accumulator width fixed at 16 b; add-3 applied to all four nibbles in parallel each iteration.
// TESTING
//  1 Reset, i_Binario=0, pulse i_Inicio -> after 15 cycles o_Listo=1 for 1 cycle, digits 0,0,0,0, o_Desborde=0.
//  2 i_Binario=1234 start -> o_Datos_3..0=1,2,3,4 exactly at edge E+15; o_Ocupado high cycles E+1..E+15 only.
//  3 i_Binario=9999 -> 9,9,9,9, Desborde=0; then 10000 -> 9,9,9,9, Desborde=1; 16383 -> 9,9,9,9, Desborde=1.
//  4 Start 4321, re-pulse i_Inicio with 0005 at E+5 and at FIN cycle -> result 4,3,2,1; only one o_Listo.
//  5 Start 5678, assert i_Reset at E+7 -> all outputs 0 immediately, no o_Listo; new start 0042 -> 0,0,4,2.
//  6 Sweep all 0..9999 with back-to-back starts (i_Inicio held high) -> each result matches reference model,
//   o_Listo period = 16 cycles, digits stable between pulses.

Source files
------------

// File: rtl/convertidor_bin_a_bcd_if.sv
// rtl/convertidor_bin_a_bcd_if.sv - start request and BCD result bundle of the binary-to-BCD converter
// The requester (master) drives value and start; the converter (slave) returns digits and status.
interface convertidor_bin_a_bcd_if #(
  parameter int ANCHO_BIN = 14
);
  logic [ANCHO_BIN-1:0] i_Binario;
  logic                 i_Inicio;
  logic [3:0]           o_Datos_0;
  logic [3:0]           o_Datos_1;
  logic [3:0]           o_Datos_2;
  logic [3:0]           o_Datos_3;
  logic                 o_Ocupado;
  logic                 o_Listo;
  logic                 o_Desborde;

  modport master (
    output i_Binario,
    output i_Inicio,
    input  o_Datos_0,
    input  o_Datos_1,
    input  o_Datos_2,
    input  o_Datos_3,
    input  o_Ocupado,
    input  o_Listo,
    input  o_Desborde
  );

  modport slave (
    input  i_Binario,
    input  i_Inicio,
    output o_Datos_0,
    output o_Datos_1,
    output o_Datos_2,
    output o_Datos_3,
    output o_Ocupado,
    output o_Listo,
    output o_Desborde
  );
endinterface

// File: rtl/convertidor_bin_a_bcd.sv
// rtl/convertidor_bin_a_bcd.sv - sequential shift-and-add-3 binary-to-BCD converter, 4 digits
// One iteration per clock; result digits are held until the next conversion completes.
module convertidor_bin_a_bcd #(
  parameter int ANCHO_BIN = 14
) (
  input  logic                    i_Reloj,
  input  logic                    i_Reset,
  convertidor_bin_a_bcd_if.slave  bus
);

  localparam int ANCHO_CNT = $clog2(ANCHO_BIN + 1);

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    DESPLAZA = 2'd1,
    FIN      = 2'd2
  } estado_t;

  estado_t                    estado;
  estado_t                    estado_sig;
  logic                       cargar;
  logic                       iterar;
  logic                       publicar;

  logic [ANCHO_BIN-1:0]       bin_reg;
  logic [15:0]                bcd_reg;
  logic [ANCHO_CNT-1:0]       cnt;
  logic                       ovf;
  logic [15:0]                datos;
  logic                       ocupado;
  logic                       listo;
  logic                       desborde;

  logic [15:0]                ajustado;
  logic [16+ANCHO_BIN-1:0]    desplazado;
  logic                       excede;

  function automatic logic [15:0] suma_tres(input logic [15:0] bcd);
    logic [15:0] r;
    logic [3:0]  nib;
    r = bcd;
    for (int i = 0; i < 4; i++) begin
      nib = bcd[4*i +: 4];
      if (nib >= 4'd5) begin
        r[4*i +: 4] = nib + 4'd3;
      end
    end
    return r;
  endfunction

  // All four nibbles are corrected in parallel before the combined shift.
  assign ajustado   = suma_tres(bcd_reg);
  assign desplazado = {ajustado, bin_reg} << 1;
  assign excede     = 16'(bus.i_Binario) > 16'd9999;

  always_comb begin
    estado_sig = estado;
    cargar     = 1'b0;
    iterar     = 1'b0;
    publicar   = 1'b0;
    case (estado)
      REPOSO: begin
        if (bus.i_Inicio) begin
          cargar     = 1'b1;
          estado_sig = DESPLAZA;
        end
      end
      DESPLAZA: begin
        iterar = 1'b1;
        if (cnt == ANCHO_CNT'(1)) begin
          estado_sig = FIN;
        end
      end
      FIN: begin
        publicar   = 1'b1;
        estado_sig = REPOSO;
      end
      default: begin
        estado_sig = REPOSO;
      end
    endcase
  end

  always_ff @(posedge i_Reloj or posedge i_Reset) begin
    if (i_Reset) begin
      estado   <= REPOSO;
      bin_reg  <= '0;
      bcd_reg  <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      datos    <= '0;
      ocupado  <= 1'b0;
      listo    <= 1'b0;
      desborde <= 1'b0;
    end else begin
      estado  <= estado_sig;
      ocupado <= (estado_sig != REPOSO);
      listo   <= publicar;
      if (cargar) begin
        bin_reg <= bus.i_Binario;
        bcd_reg <= '0;
        cnt     <= ANCHO_CNT'(ANCHO_BIN);
        ovf     <= excede;
      end
      if (iterar) begin
        {bcd_reg, bin_reg} <= desplazado;
        cnt                <= cnt - ANCHO_CNT'(1);
      end
      // Out-of-range inputs saturate so the display never shows a wrapped value.
      if (publicar) begin
        datos    <= ovf ? 16'h9999 : bcd_reg;
        desborde <= ovf;
      end
    end
  end

  assign bus.o_Datos_0  = datos[3:0];
  assign bus.o_Datos_1  = datos[7:4];
  assign bus.o_Datos_2  = datos[11:8];
  assign bus.o_Datos_3  = datos[15:12];
  assign bus.o_Ocupado  = ocupado;
  assign bus.o_Listo    = listo;
  assign bus.o_Desborde = desborde;

endmodule

// File: tb/tb_convertidor_bin_a_bcd.sv
// tb/tb_convertidor_bin_a_bcd.sv - directed self-checking bench for the binary-to-BCD converter
module tb_convertidor_bin_a_bcd;

  localparam int ANCHO = 14;

  logic i_Reloj = 1'b0;
  logic i_Reset;
  int   checks = 0;
  int   errors = 0;

  always #5 i_Reloj = ~i_Reloj;

  convertidor_bin_a_bcd_if #(.ANCHO_BIN(ANCHO)) bus ();

  convertidor_bin_a_bcd #(.ANCHO_BIN(ANCHO)) dut (
    .i_Reloj (i_Reloj),
    .i_Reset (i_Reset),
    .bus     (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] digitos();
    return {bus.o_Datos_3, bus.o_Datos_2, bus.o_Datos_1, bus.o_Datos_0};
  endfunction

  function automatic logic [15:0] modelo(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'((s / 1000) % 10), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic tick();
    @(posedge i_Reloj);
    #1;
  endtask

  task automatic convertir(input string tag, input int v, input logic [15:0] exp_bcd, input logic exp_ovf);
    logic [ANCHO-1:0] b;
    int lat;
    b = v[ANCHO-1:0];
    bus.i_Binario = b;
    bus.i_Inicio  = 1'b1;
    tick();
    bus.i_Inicio = 1'b0;
    lat = 0;
    while (!bus.o_Listo && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 15);
    check({tag, "_digits"}, digitos(), exp_bcd);
    check({tag, "_ovf"}, bus.o_Desborde, exp_ovf);
    tick();
    check({tag, "_listo_one_cycle"}, bus.o_Listo, 1'b0);
  endtask

  task automatic contar_listo(input string tag, input int ciclos);
    int n;
    n = 0;
    for (int k = 0; k < ciclos; k++) begin
      tick();
      if (bus.o_Listo) n++;
    end
    check(tag, n, 0);
  endtask

  initial begin
    int ocup;
    int vals[$];
    logic [15:0] last;
    logic stable;
    int n;

    i_Reset       = 1'b1;
    bus.i_Binario = '0;
    bus.i_Inicio  = 1'b0;
    #1;
    check("reset_digits", digitos(), 16'h0000);
    check("reset_ocupado", bus.o_Ocupado, 1'b0);
    check("reset_listo", bus.o_Listo, 1'b0);
    check("reset_desborde", bus.o_Desborde, 1'b0);
    tick();
    tick();
    i_Reset = 1'b0;
    tick();

    // 1: zero
    convertir("zero", 0, 16'h0000, 1'b0);

    // 2: 1234 with busy window check
    bus.i_Binario = 14'd1234;
    bus.i_Inicio  = 1'b1;
    tick();
    bus.i_Inicio = 1'b0;
    ocup = 0;
    for (int k = 0; k < 15; k++) begin
      if (bus.o_Ocupado) ocup++;
      check("v1234_no_early_listo", bus.o_Listo, 1'b0);
      if (k < 14) tick();
    end
    check("v1234_busy_cycles", ocup, 15);
    tick();
    check("v1234_listo_at_e15", bus.o_Listo, 1'b1);
    check("v1234_digits", digitos(), 16'h1234);
    check("v1234_ocupado_low", bus.o_Ocupado, 1'b0);
    tick();

    // 3: saturation boundaries
    convertir("v9999", 9999, 16'h9999, 1'b0);
    convertir("v10000", 10000, 16'h9999, 1'b1);
    convertir("v16383", 16383, 16'h9999, 1'b1);
    convertir("v0001", 1, 16'h0001, 1'b0);
    convertir("v0809", 809, 16'h0809, 1'b0);

    // 4: restarts during conversion are ignored
    bus.i_Binario = 14'd4321;
    bus.i_Inicio  = 1'b1;
    tick();
    bus.i_Inicio = 1'b0;
    repeat (4) tick();
    bus.i_Binario = 14'd5;
    bus.i_Inicio  = 1'b1;
    tick();
    bus.i_Inicio = 1'b0;
    repeat (9) tick();
    bus.i_Inicio = 1'b1;
    tick();
    bus.i_Inicio = 1'b0;
    check("ignore_listo", bus.o_Listo, 1'b1);
    check("ignore_digits", digitos(), 16'h4321);
    contar_listo("ignore_extra_listo", 20);

    // 5: reset mid-conversion
    bus.i_Binario = 14'd5678;
    bus.i_Inicio  = 1'b1;
    tick();
    bus.i_Inicio = 1'b0;
    repeat (6) tick();
    #2;
    i_Reset = 1'b1;
    #1;
    check("abort_digits", digitos(), 16'h0000);
    check("abort_ocupado", bus.o_Ocupado, 1'b0);
    check("abort_listo", bus.o_Listo, 1'b0);
    tick();
    tick();
    i_Reset = 1'b0;
    contar_listo("abort_no_listo", 20);
    convertir("v0042", 42, 16'h0042, 1'b0);

    // 6: back-to-back sweep over low, high and spread values
    for (int v = 0; v < 300; v++) vals.push_back(v);
    for (int v = 300; v < 9700; v += 997) vals.push_back(v);
    for (int v = 9700; v < 10000; v++) vals.push_back(v);
    last = digitos();
    bus.i_Binario = vals[0][ANCHO-1:0];
    bus.i_Inicio  = 1'b1;
    tick();
    for (int i = 0; i < vals.size(); i++) begin
      n = 0;
      stable = 1'b1;
      do begin
        tick();
        n++;
        if (!bus.o_Listo && digitos() !== last) stable = 1'b0;
      end while (!bus.o_Listo && n < 40);
      check("sweep_period", n, (i == 0) ? 15 : 16);
      check("sweep_stable", stable, 1'b1);
      check("sweep_digits", digitos(), modelo(vals[i]));
      check("sweep_ovf", bus.o_Desborde, 1'b0);
      last = digitos();
      if (i + 1 < vals.size()) begin
        bus.i_Binario = vals[i+1][ANCHO-1:0];
      end else begin
        bus.i_Inicio = 1'b0;
      end
      if (n >= 40) break;
    end
    tick();
    check("sweep_end_listo", bus.o_Listo, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
